// File: rtl/aia_msi_tx.sv
// rtl/aia_msi_tx.sv - AIA MSI transmitter: request FIFO feeding AXI-Lite writes to IMSIC seteipnum_le (optional AIA_MSI_TX_ERR_CNT_EN)
module aia_msi_tx #(
  parameter int unsigned NrHarts    = 1,
  parameter logic [63:0] IMSICBase  = 64'h2400_0000,
  parameter logic [63:0] HartStride = 64'h1000,
  parameter int unsigned FifoDepth  = 4,
  localparam int unsigned HartW     = (NrHarts > 1) ? $clog2(NrHarts) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [HartW-1:0] req_hart_i,
  input  logic [10:0]      req_eiid_i,
  output logic             aw_valid_o,
  input  logic             aw_ready_i,
  output logic [63:0]      aw_addr_o,
  output logic             w_valid_o,
  input  logic             w_ready_i,
  output logic [31:0]      w_data_o,
  output logic [3:0]       w_strb_o,
  input  logic             b_valid_i,
  output logic             b_ready_o,
  input  logic [1:0]       b_resp_i,
`ifdef AIA_MSI_TX_ERR_CNT_EN
  output logic [7:0]       err_cnt_o,
`endif
  output logic             busy_o,
  output logic             err_o
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(FifoDepth);
  localparam logic [HartW:0] NrHartsW = (HartW + 1)'(NrHarts);

  typedef enum logic [1:0] {IDLE, SEND, RESP} state_t;

  // request buffer
  logic [HartW-1:0] fifo_hart [FifoDepth];
  logic [10:0]      fifo_eiid [FifoDepth];
  logic [PtrW-1:0]  wr_ptr, rd_ptr;
  logic [CntW-1:0]  count;
  logic             req_ok, push, pop;

  // write channel state
  state_t      state_q, state_d;
  logic        aw_valid_q, aw_valid_d;
  logic        w_valid_q, w_valid_d;
  logic [63:0] aw_addr_q, aw_addr_d;
  logic [31:0] w_data_q, w_data_d;
  logic [3:0]  w_strb_q, w_strb_d;
  logic        err_q, err_d;
  logic        aw_pend, w_pend;

  // only the error bit of the response matters; OKAY and EXOKAY are both success
  logic unused_resp_lsb;
  assign unused_resp_lsb = b_resp_i[0];

  // ready depends only on the registered count, never on AXI inputs
  assign req_ready_o = (count != FullCnt);
  assign req_ok      = (req_eiid_i != 11'd0) && ({1'b0, req_hart_i} < NrHartsW);
  assign push        = req_valid_i && req_ready_o && req_ok;

  // buffer storage needs no reset: validity lives in the pointers and count
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_hart[wr_ptr] <= req_hart_i;
      fifo_eiid[wr_ptr] <= req_eiid_i;
    end
  end

  // pointers and occupancy; a same-cycle push and pop leave the count unchanged
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
      case ({push, pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  // state and registered AXI outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      aw_addr_q  <= aw_addr_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      err_q      <= err_d;
    end
  end

  // next state: pop a request, drive AW/W until each handshakes, then await B
  always_comb begin
    state_d    = state_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    aw_addr_d  = aw_addr_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    err_d      = 1'b0;
    pop        = 1'b0;
    aw_pend    = aw_valid_q && !aw_ready_i;
    w_pend     = w_valid_q && !w_ready_i;
    case (state_q)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          aw_valid_d = 1'b1;
          w_valid_d  = 1'b1;
          aw_addr_d  = IMSICBase + 64'(fifo_hart[rd_ptr]) * HartStride;
          w_data_d   = {21'b0, fifo_eiid[rd_ptr]};
          w_strb_d   = 4'hF;
          state_d    = SEND;
        end
      end
      SEND: begin
        aw_valid_d = aw_pend;
        w_valid_d  = w_pend;
        if (!aw_pend && !w_pend) state_d = RESP;
      end
      RESP: begin
        if (b_valid_i) begin
          state_d = IDLE;
          err_d   = b_resp_i[1];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign aw_valid_o = aw_valid_q;
  assign w_valid_o  = w_valid_q;
  assign aw_addr_o  = aw_addr_q;
  assign w_data_o   = w_data_q;
  assign w_strb_o   = w_strb_q;
  assign b_ready_o  = (state_q == RESP);
  assign err_o      = err_q;
  assign busy_o     = (count != '0) || (state_q != IDLE);

`ifdef AIA_MSI_TX_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  // saturating count of error responses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_q <= '0;
    end else if (err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_aia_msi_tx.sv
// tb/tb_aia_msi_tx.sv - self-checking bench for aia_msi_tx (honours AIA_MSI_TX_ERR_CNT_EN)
module tb_aia_msi_tx;

  localparam int NR = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [1:0]  req_hart_i = '0;
  logic [10:0] req_eiid_i = '0;
  logic        aw_valid_o;
  logic        aw_ready_i = 1'b1;
  logic [63:0] aw_addr_o;
  logic        w_valid_o;
  logic        w_ready_i = 1'b1;
  logic [31:0] w_data_o;
  logic [3:0]  w_strb_o;
  logic        b_valid_i = 1'b1;
  logic        b_ready_o;
  logic [1:0]  b_resp_i = 2'b00;
  logic        busy_o;
  logic        err_o;
`ifdef AIA_MSI_TX_ERR_CNT_EN
  logic [7:0]  err_cnt_o;
  logic [7:0]  err_cnt_b;
`endif

  // second instance with a non-power-of-two hart count so hart == NrHarts is encodable
  logic        req_valid_b = 1'b0;
  logic        req_ready_b, aw_valid_b, w_valid_b, b_ready_b, busy_b, err_b;
  logic [63:0] aw_addr_b;
  logic [31:0] w_data_b;
  logic [3:0]  w_strb_b;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt  = 0;
  int b_cnt   = 0;
  logic [63:0] exp_addr_q [$];
  logic [31:0] exp_data_q [$];

  always #5 clk_i = ~clk_i;

  aia_msi_tx #(.NrHarts(NR), .FifoDepth(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_hart_i(req_hart_i), .req_eiid_i(req_eiid_i),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o), .w_strb_o(w_strb_o),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i),
`ifdef AIA_MSI_TX_ERR_CNT_EN
    .err_cnt_o(err_cnt_o),
`endif
    .busy_o(busy_o), .err_o(err_o)
  );

  aia_msi_tx #(.NrHarts(3), .FifoDepth(4)) dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_b), .req_ready_o(req_ready_b),
    .req_hart_i(req_hart_i), .req_eiid_i(req_eiid_i),
    .aw_valid_o(aw_valid_b), .aw_ready_i(1'b1), .aw_addr_o(aw_addr_b),
    .w_valid_o(w_valid_b), .w_ready_i(1'b1), .w_data_o(w_data_b), .w_strb_o(w_strb_b),
    .b_valid_i(1'b1), .b_ready_o(b_ready_b), .b_resp_i(2'b00),
`ifdef AIA_MSI_TX_ERR_CNT_EN
    .err_cnt_o(err_cnt_b),
`endif
    .busy_o(busy_b), .err_o(err_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // monitor: sampled on the falling edge, so it sees what the next rising edge will capture
  logic        aw_seen = 1'b0, w_seen = 1'b0, aw_hold = 1'b0, w_hold = 1'b0;
  logic [63:0] aw_cap, aw_prev;
  logic [31:0] w_cap, w_prev;
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      aw_seen = 1'b0; w_seen = 1'b0; aw_hold = 1'b0; w_hold = 1'b0;
    end else begin
      if (aw_hold && aw_valid_o) check("aw_addr_stable", aw_addr_o, aw_prev);
      if (w_hold && w_valid_o)   check("w_data_stable", w_data_o, w_prev);
      aw_hold = aw_valid_o && !aw_ready_i;
      w_hold  = w_valid_o && !w_ready_i;
      aw_prev = aw_addr_o;
      w_prev  = w_data_o;
      if (aw_valid_o && aw_ready_i) begin
        check("aw_no_duplicate", aw_seen, 1'b0);
        aw_seen = 1'b1;
        aw_cap  = aw_addr_o;
      end
      if (w_valid_o && w_ready_i) begin
        check("w_no_duplicate", w_seen, 1'b0);
        check("w_strb", w_strb_o, 4'hF);
        w_seen = 1'b1;
        w_cap  = w_data_o;
      end
      if (aw_seen && w_seen) begin
        n_tests++;
        assert (exp_addr_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_write observed=0x%0h expected=none", aw_cap);
        end
        if (exp_addr_q.size() != 0) begin
          check("sb_aw_addr", aw_cap, exp_addr_q.pop_front());
          check("sb_w_data", w_cap, exp_data_q.pop_front());
        end
        wr_cnt++;
        aw_seen = 1'b0;
        w_seen  = 1'b0;
      end
      if (b_valid_i && b_ready_o) b_cnt++;
    end
  end

  // present a request at posedge+1 and hold it until accepted; leaves valid high
  task automatic send_req(input logic [1:0] h, input logic [10:0] e);
    logic rdy;
    logic done;
    rdy  = 1'b0;
    done = 1'b0;
    req_valid_i = 1'b1;
    req_hart_i  = h;
    req_eiid_i  = e;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk_i);
      rdy = req_ready_o;
      @(posedge clk_i);
      #1;
      if (rdy) begin
        done = 1'b1;
        if (e != 11'd0 && int'(h) < NR) begin
          exp_addr_q.push_back(64'h2400_0000 + 64'(h) * 64'h1000);
          exp_data_q.push_back({21'b0, e});
        end
      end
    end
    if (!done) check("req_accept_timeout", done, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 100 && !idle; i++) begin
      @(negedge clk_i);
      idle = !busy_o;
    end
    check(tag, idle, 1'b1);
  endtask

  task automatic wait_bresp(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_i);
      seen = b_ready_o && b_valid_i;
    end
    check(tag, seen, 1'b1);
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_aw_valid", aw_valid_o, 1'b0);
    check("rst_w_valid", w_valid_o, 1'b0);
    check("rst_b_ready", b_ready_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_aw_addr", aw_addr_o, 64'h0);
    check("rst_w_data", w_data_o, 32'h0);
    check("rst_w_strb", w_strb_o, 4'h0);
`ifdef AIA_MSI_TX_ERR_CNT_EN
    check("rst_err_cnt", err_cnt_o, 8'h00);
`endif
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    check("rst_req_ready", req_ready_o, 1'b1);

    // hart 0, eiid 5, all readies high: AW/W valid two cycles after acceptance
    @(posedge clk_i); #1;
    send_req(2'd0, 11'd5);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    check("lat_n1_aw_valid", aw_valid_o, 1'b0);
    check("lat_n1_busy", busy_o, 1'b1);
    @(negedge clk_i);
    check("lat_n2_aw_valid", aw_valid_o, 1'b1);
    check("lat_n2_w_valid", w_valid_o, 1'b1);
    check("t1_aw_addr", aw_addr_o, 64'h2400_0000);
    check("t1_w_data", w_data_o, 32'h5);
    check("t1_w_strb", w_strb_o, 4'hF);
    wait_idle("t1_idle");
    check("t1_b_ready", b_ready_o, 1'b0);
    check("t1_wr_cnt", wr_cnt, 1);
    check("t1_b_cnt", b_cnt, 1);

    // hart 3, eiid 0x7FF
    @(posedge clk_i); #1;
    send_req(2'd3, 11'h7FF);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    check("t2_aw_addr", aw_addr_o, 64'h2400_3000);
    check("t2_w_data", w_data_o, 32'h7FF);
    wait_idle("t2_idle");

    // AW ready delayed, W ready immediate
    @(posedge clk_i); #1;
    aw_ready_i = 1'b0;
    send_req(2'd1, 11'd9);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    check("t3_aw_valid_n2", aw_valid_o, 1'b1);
    check("t3_w_valid_n2", w_valid_o, 1'b1);
    @(negedge clk_i);
    check("t3_w_valid_dropped", w_valid_o, 1'b0);
    check("t3_aw_valid_held", aw_valid_o, 1'b1);
    check("t3_b_ready_early", b_ready_o, 1'b0);
    @(posedge clk_i); #1;
    aw_ready_i = 1'b1;
    wait_idle("t3_idle");
    check("t3_wr_cnt", wr_cnt, 3);
    check("t3_b_cnt", b_cnt, 3);

    // back-to-back with AW stalled: buffer fills, further requests stall, order kept
    @(posedge clk_i); #1;
    aw_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) send_req(2'(k % 4), 11'h10 + 11'(k));
    req_hart_i  = 2'd2;
    req_eiid_i  = 11'h20;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check("t4_full_ready_low", req_ready_o, 1'b0);
    end
    @(posedge clk_i); #1;
    aw_ready_i = 1'b1;
    send_req(2'd2, 11'h20);
    req_valid_i = 1'b0;
    wait_idle("t4_idle");
    check("t4_wr_cnt", wr_cnt, 9);

    // discarded requests: eiid 0, and hart == NrHarts on the 3-hart instance
    @(posedge clk_i); #1;
    send_req(2'd1, 11'd0);
    req_valid_i = 1'b0;
    req_valid_b = 1'b1;
    req_hart_i  = 2'd3;
    req_eiid_i  = 11'd5;
    @(posedge clk_i); #1;
    req_valid_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      check("t5_busy", busy_o, 1'b0);
      check("t5_aw_valid", aw_valid_o, 1'b0);
      check("t5_busy_b", busy_b, 1'b0);
      check("t5_aw_valid_b", aw_valid_b, 1'b0);
    end
    check("t5_wr_cnt", wr_cnt, 9);

    // SLVERR response: one-cycle error pulse
    @(posedge clk_i); #1;
    b_resp_i = 2'b10;
    send_req(2'd2, 11'd3);
    req_valid_i = 1'b0;
    wait_bresp("t6_bresp_seen");
    check("t6_err_before", err_o, 1'b0);
    @(negedge clk_i);
    check("t6_err_pulse", err_o, 1'b1);
    @(negedge clk_i);
    check("t6_err_end", err_o, 1'b0);
`ifdef AIA_MSI_TX_ERR_CNT_EN
    check("t6_err_cnt", err_cnt_o, 8'h01);
`endif
    @(posedge clk_i); #1;
    b_resp_i = 2'b00;
    wait_idle("t6_idle");

    // reset while waiting for B, with two requests still queued
    @(posedge clk_i); #1;
    b_valid_i = 1'b0;
    send_req(2'd0, 11'd1);
    send_req(2'd1, 11'd2);
    send_req(2'd2, 11'd3);
    req_valid_i = 1'b0;
    for (int i = 0; i < 50 && !b_ready_o; i++) @(negedge clk_i);
    check("t7_in_resp", b_ready_o, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    check("t7_rst_aw_valid", aw_valid_o, 1'b0);
    check("t7_rst_w_valid", w_valid_o, 1'b0);
    check("t7_rst_b_ready", b_ready_o, 1'b0);
    check("t7_rst_busy", busy_o, 1'b0);
    check("t7_rst_req_ready", req_ready_o, 1'b1);
`ifdef AIA_MSI_TX_ERR_CNT_EN
    check("t7_rst_err_cnt", err_cnt_o, 8'h00);
`endif
    exp_addr_q.delete();
    exp_data_q.delete();
    @(posedge clk_i); #1;
    rst_ni    = 1'b1;
    b_valid_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      check("t7_no_replay_aw", aw_valid_o, 1'b0);
      check("t7_no_replay_busy", busy_o, 1'b0);
    end
    check("t7_wr_cnt", wr_cnt, 11);
    check("t7_b_cnt", b_cnt, 10);
    check("sb_empty", exp_addr_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
